// File: rtl/scs8hd_scan_seq.sv
// Scan-chain sequencer: shifts a parallel pattern into a scan chain, pulses one
// functional capture cycle, then unloads the chain's response into RESP.
module scs8hd_scan_seq #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PATTERN,
    input  logic                 SO,
    output logic                 SCE,
    output logic                 SCD,
    output logic                 DE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_FIN
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_last;
    logic                 w_accept;
    logic [CHAIN_LEN-1:0] r_shadow;
    logic [CHAIN_LEN-1:0] r_resp;
    logic                 r_sce;
    logic                 r_scd;
    logic                 r_de;
    logic                 r_busy;
    logic                 r_done;

    assign w_last   = (r_cnt == LAST);
    assign w_accept = (r_state == S_IDLE) && START;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = S_CAPTURE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_UNLOAD;
                w_cnt_nxt   = '0;
            end
            S_UNLOAD: begin
                if (w_last) begin
                    w_state_nxt = S_FIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are valid from the first
    // cycle of each state; SCD is pre-fetched one bit ahead from the shadow.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sce    <= 1'b0;
            r_scd    <= 1'b0;
            r_de     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_shadow <= '0;
            r_resp   <= '0;
        end else begin
            r_sce  <= (w_state_nxt == S_SHIFT) || (w_state_nxt == S_UNLOAD);
            r_de   <= (w_state_nxt == S_CAPTURE);
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_FIN);
            r_scd  <= 1'b0;
            if (w_accept) begin
                r_shadow <= PATTERN;
                r_scd    <= PATTERN[CHAIN_LEN-1];
            end else if (r_state == S_SHIFT) begin
                r_shadow <= r_shadow << 1;
                if (!w_last) begin
                    r_scd <= r_shadow[CHAIN_LEN-2];
                end
            end
            if (r_state == S_UNLOAD) begin
                r_resp <= {r_resp[CHAIN_LEN-2:0], SO};
            end
        end
    end

    assign SCE  = r_sce;
    assign SCD  = r_scd;
    assign DE   = r_de;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign RESP = r_resp;

endmodule

// File: tb/tb_scs8hd_scan_seq.sv
// Scoreboard bench: two sequencers (8- and 2-cell chains) driving behavioural
// chain models; expected RESP and DONE cycle are queued and checked on DONE.
module tb_scs8hd_scan_seq;

    typedef struct {
        logic [7:0] resp;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;

    exp_t q8[$];
    exp_t q2[$];

    logic       rst = 1'b1;
    logic       start8 = 1'b0, start2 = 1'b0;
    logic [7:0] pat8 = '0;
    logic [1:0] pat2 = '0;
    logic       so8, so2;
    logic       sce8, scd8, de8, busy8, done8;
    logic       sce2, scd2, de2, busy2, done2;
    logic [7:0] resp8;
    logic [1:0] resp2;
    logic [7:0] chain8 = '0;
    logic [1:0] chain2 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scs8hd_scan_seq #(.CHAIN_LEN(8)) u_dut8 (
        .CLK(clk), .RESET(rst), .START(start8), .PATTERN(pat8), .SO(so8),
        .SCE(sce8), .SCD(scd8), .DE(de8), .BUSY(busy8), .DONE(done8), .RESP(resp8)
    );

    scs8hd_scan_seq #(.CHAIN_LEN(2)) u_dut2 (
        .CLK(clk), .RESET(rst), .START(start2), .PATTERN(pat2), .SO(so2),
        .SCE(sce2), .SCD(scd2), .DE(de2), .BUSY(busy2), .DONE(done2), .RESP(resp2)
    );

    // 8-cell chain captures the inverse of its state; 2-cell chain captures itself.
    always @(posedge clk) begin
        if (sce8) chain8 <= {chain8[6:0], scd8};
        else if (de8) chain8 <= ~chain8;
        if (sce2) chain2 <= {chain2[0], scd2};
    end
    assign so8 = chain8[7];
    assign so2 = chain2[1];

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                chk("done8_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("resp8", resp8, e.resp);
                chk("done8_cycle", cyc, e.cyc);
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin
                chk("done2_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("resp2", resp2, e.resp);
                chk("done2_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle8();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy8 && k < 100);
        chk("idle8_timeout", busy8, 0);
    endtask

    task automatic wait_idle2();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy2 && k < 100);
        chk("idle2_timeout", busy2, 0);
    endtask

    initial begin
        int c0;
        logic [7:0] p;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset8_ctl", {sce8, scd8, de8, busy8, done8}, 0);
        chk("reset8_resp", resp8, 0);
        chk("reset2_ctl", {sce2, scd2, de2, busy2, done2}, 0);
        chk("reset2_resp", resp2, 0);

        // Load order and full sequence, 8 cells, inverting capture.
        p = 8'hA5;
        pat8 = p;
        start8 = 1'b1;
        @(negedge clk);
        c0 = cyc;
        start8 = 1'b0;
        q8.push_back('{8'h5A, c0 + 17});
        for (int i = 0; i < 8; i++) begin
            chk("shift_scd", scd8, p[7-i]);
            chk("shift_sce", sce8, 1);
            @(negedge clk);
        end
        chk("cap_de", de8, 1);
        chk("cap_sce", sce8, 0);
        chk("cap_chain", chain8, 8'hA5);
        @(negedge clk);
        chk("cap_de_pulse", de8, 0);
        chk("unload_sce", sce8, 1);
        wait_idle8();

        // START pulsed mid-SHIFT with a new PATTERN must be ignored.
        pat8 = 8'hA5;
        start8 = 1'b1;
        @(negedge clk);
        c0 = cyc;
        start8 = 1'b0;
        q8.push_back('{8'h5A, c0 + 17});
        repeat (4) @(negedge clk);
        pat8 = 8'hFF;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle8();
        repeat (3) @(negedge clk);
        chk("no_restart_busy", busy8, 0);

        // Reset held for 2 cycles mid-SHIFT.
        pat8 = 8'hA5;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_sce", sce8, 0);
        chk("midrst_de", de8, 0);
        chk("midrst_busy", busy8, 0);
        chk("midrst_resp", resp8, 0);

        // RESET and START together: START is dropped.
        rst = 1'b1;
        start8 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start8 = 1'b0;
        chk("rst_start_busy", busy8, 0);
        @(negedge clk);
        chk("rst_start_dropped", busy8, 0);

        // Back-to-back with START held high: period 19, one IDLE cycle.
        pat8 = 8'h3C;
        start8 = 1'b1;
        @(negedge clk);
        c0 = cyc;
        for (int k = 0; k < 3; k++) q8.push_back('{8'hC3, c0 + 19 * k + 17});
        while (cyc < c0 + 18) @(negedge clk);
        chk("b2b_idle_gap", busy8, 0);
        @(negedge clk);
        chk("b2b_restart", busy8, 1);
        while (cyc < c0 + 40) @(negedge clk);
        start8 = 1'b0;
        wait_idle8();

        // 2-cell chain, identity capture.
        pat2 = 2'b10;
        start2 = 1'b1;
        @(negedge clk);
        c0 = cyc;
        start2 = 1'b0;
        q2.push_back('{8'h02, c0 + 5});
        chk("n2_scd0", scd2, 1);
        @(negedge clk);
        chk("n2_scd1", scd2, 0);
        @(negedge clk);
        chk("n2_cap_de", de2, 1);
        wait_idle2();

        repeat (5) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
